// File: rtl/memory_stage_pkg.sv
// Shared encodings, pipeline-register layouts and lane helpers for the MIPS MEM stage.
package memory_stage_pkg;

  localparam int DMEM_DEPTH_DEFAULT = 1024;

  localparam logic [1:0] SZ_WORD = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_BYTE = 2'b10;

  typedef struct packed {
    logic        valid;
    logic [31:0] alu;
    logic        zero;
    logic [31:0] store_data;
    logic [4:0]  dest;
    logic [31:0] target;
    logic        mem_read;
    logic        mem_write;
    logic [1:0]  size;
    logic        load_unsigned;
    logic        branch;
    logic        reg_write;
    logic        mem_to_reg;
  } ex_mem_t;

  typedef struct packed {
    logic [31:0] data;
    logic [4:0]  dest;
    logic        reg_write;
  } mem_wb_t;

  // The reserved size code behaves as a word everywhere.
  function automatic logic [3:0] byte_enables(input logic [1:0] size, input logic [1:0] addr);
    case (size)
      SZ_HALF: return addr[1] ? 4'b1100 : 4'b0011;
      SZ_BYTE: return 4'b0001 << addr;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_lanes(input logic [1:0] size, input logic [31:0] data);
    case (size)
      SZ_HALF: return {2{data[15:0]}};
      SZ_BYTE: return {4{data[7:0]}};
      default: return data;
    endcase
  endfunction

  function automatic logic [31:0] load_extend(input logic [1:0] size, input logic [1:0] addr,
                                              input logic is_unsigned, input logic [31:0] word);
    logic [15:0] half;
    logic [7:0]  bval;
    half = addr[1] ? word[31:16] : word[15:0];
    bval = word[{addr, 3'b000} +: 8];
    case (size)
      SZ_HALF: return is_unsigned ? {16'h0, half} : {{16{half[15]}}, half};
      SZ_BYTE: return is_unsigned ? {24'h0, bval} : {{24{bval[7]}}, bval};
      default: return word;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr);
    case (size)
      SZ_HALF: return addr[0];
      SZ_BYTE: return 1'b0;
      default: return addr != 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/memory_stage_if.sv
// Pipeline-side signal bundle of the MEM stage; master is the EX/control side, slave is memory_stage.
interface memory_stage_if;
  logic        Stall_in;
  logic        Flush_in;
  logic [31:0] ALUResult_in;
  logic        Zero_in;
  logic [31:0] StoreData_in;
  logic [4:0]  RtRd_in;
  logic [31:0] BranchTarget_in;
  logic        MemRead_in;
  logic        MemWrite_in;
  logic [1:0]  MemSize_in;
  logic        LoadUnsigned_in;
  logic        Branch_in;
  logic        RegWrite_in;
  logic        MemToReg_in;
  logic        PCSrc_out;
  logic [31:0] BranchTarget_out;
  logic [31:0] ExMemALU_out;
  logic [4:0]  ExMemDest_out;
  logic        ExMemRegWrite_out;
  logic [31:0] WBData_out;
  logic [4:0]  WBDest_out;
  logic        RegWrite_out;
  logic        AlignErr_out;

  modport master (
    output Stall_in, Flush_in, ALUResult_in, Zero_in, StoreData_in, RtRd_in, BranchTarget_in,
           MemRead_in, MemWrite_in, MemSize_in, LoadUnsigned_in, Branch_in, RegWrite_in, MemToReg_in,
    input  PCSrc_out, BranchTarget_out, ExMemALU_out, ExMemDest_out, ExMemRegWrite_out,
           WBData_out, WBDest_out, RegWrite_out, AlignErr_out
  );

  modport slave (
    input  Stall_in, Flush_in, ALUResult_in, Zero_in, StoreData_in, RtRd_in, BranchTarget_in,
           MemRead_in, MemWrite_in, MemSize_in, LoadUnsigned_in, Branch_in, RegWrite_in, MemToReg_in,
    output PCSrc_out, BranchTarget_out, ExMemALU_out, ExMemDest_out, ExMemRegWrite_out,
           WBData_out, WBDest_out, RegWrite_out, AlignErr_out
  );
endinterface

// File: rtl/memory_stage_data_memory.sv
// Byte-enabled data RAM: synchronous write, asynchronous read, DEPTH x 32.
module data_memory #(
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              we,
  input  logic [3:0]        be,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [31:0]       wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [31:0]       rdata
);

  logic [31:0] mem_q [DEPTH];

  // NOTE: the array has no reset; clearing it would turn the RAM into a huge flop bank.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem_q[waddr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/memory_stage.sv
// MIPS MEM stage: EX/MEM register, data memory access, branch resolve, MEM/WB register.
// Optional build macro MEM_ALIGN_TRAP_EN: trap misaligned word/half accesses instead of aligning down.
module memory_stage
  import memory_stage_pkg::*;
#(
  parameter int DMEM_DEPTH = DMEM_DEPTH_DEFAULT,
  parameter int ADDR_W     = $clog2(DMEM_DEPTH)
) (
  input  logic          Clk,
  input  logic          Rst,
  memory_stage_if.slave bus
);

  ex_mem_t           ex_mem_d, ex_mem_q;
  mem_wb_t           mem_wb_d, mem_wb_q;
  logic [1:0]        addr_lo;
  logic              mem_op;
  logic              misaligned;
  logic              dmem_we;
  logic [ADDR_W-1:0] dmem_idx;
  logic [31:0]       dmem_rdata;
  logic [31:0]       load_data;

  // NOTE: every field gets a default first so no path through the block infers a latch.
  always_comb begin
    ex_mem_d = ex_mem_q;
    if (bus.Flush_in) begin
      ex_mem_d.valid = 1'b0;
    end else if (!bus.Stall_in) begin
      ex_mem_d = '{valid:         1'b1,
                   alu:           bus.ALUResult_in,
                   zero:          bus.Zero_in,
                   store_data:    bus.StoreData_in,
                   dest:          bus.RtRd_in,
                   target:        bus.BranchTarget_in,
                   mem_read:      bus.MemRead_in,
                   mem_write:     bus.MemWrite_in,
                   size:          bus.MemSize_in,
                   load_unsigned: bus.LoadUnsigned_in,
                   branch:        bus.Branch_in,
                   reg_write:     bus.RegWrite_in,
                   mem_to_reg:    bus.MemToReg_in};
    end
  end

  assign addr_lo  = ex_mem_q.alu[1:0];
  assign mem_op   = ex_mem_q.mem_read | ex_mem_q.mem_write;
  assign dmem_idx = ex_mem_q.alu[ADDR_W+1:2];

`ifdef MEM_ALIGN_TRAP_EN
  assign misaligned = mem_op & is_misaligned(ex_mem_q.size, addr_lo);
`else
  // Word/half lanes only look at addr[1], so low bits are ignored naturally.
  assign misaligned = 1'b0;
`endif

  assign dmem_we = ex_mem_q.valid & ex_mem_q.mem_write & !bus.Stall_in & !misaligned;

  data_memory #(.DEPTH(DMEM_DEPTH), .ADDR_W(ADDR_W)) u_dmem (
    .clk   (Clk),
    .we    (dmem_we),
    .be    (byte_enables(ex_mem_q.size, addr_lo)),
    .waddr (dmem_idx),
    .wdata (store_lanes(ex_mem_q.size, ex_mem_q.store_data)),
    .raddr (dmem_idx),
    .rdata (dmem_rdata)
  );

  assign load_data = load_extend(ex_mem_q.size, addr_lo, ex_mem_q.load_unsigned, dmem_rdata);

  always_comb begin
    mem_wb_d = mem_wb_q;
    if (!bus.Stall_in) begin
      mem_wb_d.data      = ex_mem_q.mem_to_reg ? load_data : ex_mem_q.alu;
      mem_wb_d.dest      = ex_mem_q.dest;
      mem_wb_d.reg_write = ex_mem_q.valid & ex_mem_q.reg_write & !misaligned;
    end
  end

  // NOTE: sequential state uses non-blocking assignment so all flops update together.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      ex_mem_q <= '0;
      mem_wb_q <= '0;
    end else begin
      ex_mem_q <= ex_mem_d;
      mem_wb_q <= mem_wb_d;
    end
  end

`ifdef MEM_ALIGN_TRAP_EN
  logic align_err_d, align_err_q;

  assign align_err_d = align_err_q | (ex_mem_q.valid & misaligned & !bus.Stall_in);

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) align_err_q <= 1'b0;
    else      align_err_q <= align_err_d;
  end

  assign bus.AlignErr_out = align_err_q;
`else
  assign bus.AlignErr_out = 1'b0;
`endif

  assign bus.PCSrc_out         = ex_mem_q.valid & ex_mem_q.branch & ex_mem_q.zero;
  assign bus.BranchTarget_out  = ex_mem_q.target;
  assign bus.ExMemALU_out      = ex_mem_q.alu;
  assign bus.ExMemDest_out     = ex_mem_q.dest;
  assign bus.ExMemRegWrite_out = ex_mem_q.valid & ex_mem_q.reg_write;
  assign bus.WBData_out        = mem_wb_q.data;
  assign bus.WBDest_out        = mem_wb_q.dest;
  assign bus.RegWrite_out      = mem_wb_q.reg_write;

endmodule

// File: tb/tb_memory_stage.sv
// Directed self-checking bench for memory_stage; follows MEM_ALIGN_TRAP_EN for the alignment case.
module tb_memory_stage;
  import memory_stage_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_err    = 0;

  memory_stage_if bus ();

  memory_stage dut (
    .Clk (clk),
    .Rst (rst_n),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] alu, input logic [31:0] sd, input logic [4:0] dest,
                       input logic rd, input logic wr, input logic [1:0] size,
                       input logic uns, input logic rw, input logic m2r);
    bus.ALUResult_in    = alu;
    bus.StoreData_in    = sd;
    bus.RtRd_in         = dest;
    bus.MemRead_in      = rd;
    bus.MemWrite_in     = wr;
    bus.MemSize_in      = size;
    bus.LoadUnsigned_in = uns;
    bus.RegWrite_in     = rw;
    bus.MemToReg_in     = m2r;
    bus.Branch_in       = 1'b0;
    bus.Zero_in         = 1'b0;
    bus.BranchTarget_in = 32'h0;
  endtask

  task automatic nop();
    drive(32'h0, 32'h0, 5'd0, 1'b0, 1'b0, SZ_WORD, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic st(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] size);
    drive(addr, data, 5'd0, 1'b0, 1'b1, size, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic ld(input logic [31:0] addr, input logic [4:0] dest, input logic [1:0] size,
                    input logic uns);
    drive(addr, 32'h0, dest, 1'b1, 1'b0, size, uns, 1'b1, 1'b1);
  endtask

  task automatic alu_op(input logic [31:0] res, input logic [4:0] dest);
    drive(res, 32'h0, dest, 1'b0, 1'b0, SZ_WORD, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic store(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] size);
    st(addr, data, size);
    tick();
    nop();
    tick();
  endtask

  task automatic load_check(input string tag, input logic [31:0] addr, input logic [1:0] size,
                            input logic uns, input logic [31:0] exp);
    ld(addr, 5'd12, size, uns);
    tick();
    nop();
    tick();
    check(tag, bus.WBData_out, exp);
    check({tag, "_rw"}, {31'h0, bus.RegWrite_out}, 32'h1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_pcsrc"}, {31'h0, bus.PCSrc_out}, 32'h0);
    check({tag, "_btgt"}, bus.BranchTarget_out, 32'h0);
    check({tag, "_exalu"}, bus.ExMemALU_out, 32'h0);
    check({tag, "_exdest"}, {27'h0, bus.ExMemDest_out}, 32'h0);
    check({tag, "_exrw"}, {31'h0, bus.ExMemRegWrite_out}, 32'h0);
    check({tag, "_wbdata"}, bus.WBData_out, 32'h0);
    check({tag, "_wbdest"}, {27'h0, bus.WBDest_out}, 32'h0);
    check({tag, "_rw"}, {31'h0, bus.RegWrite_out}, 32'h0);
    check({tag, "_aerr"}, {31'h0, bus.AlignErr_out}, 32'h0);
  endtask

  initial begin
    rst_n        = 1'b0;
    bus.Stall_in = 1'b0;
    bus.Flush_in = 1'b0;
    nop();
    tick();
    tick();
    check_all_zero("reset");
    rst_n = 1'b1;

    // sw then back-to-back lw to the same address
    st(32'h10, 32'hDEADBEEF, SZ_WORD);
    tick();
    ld(32'h10, 5'd5, SZ_WORD, 1'b0);
    tick();
    check("sw_wb_rw", {31'h0, bus.RegWrite_out}, 32'h0);
    check("lw_exdest", {27'h0, bus.ExMemDest_out}, 32'h5);
    check("lw_exrw", {31'h0, bus.ExMemRegWrite_out}, 32'h1);
    check("lw_exalu", bus.ExMemALU_out, 32'h10);
    nop();
    tick();
    check("lw_data", bus.WBData_out, 32'hDEADBEEF);
    check("lw_dest", {27'h0, bus.WBDest_out}, 32'h5);
    check("lw_rw", {31'h0, bus.RegWrite_out}, 32'h1);

    // sub-word stores and loads
    store(32'h20, 32'h11223344, SZ_WORD);
    store(32'h21, 32'h00000080, SZ_BYTE);
    load_check("lb", 32'h21, SZ_BYTE, 1'b0, 32'hFFFFFF80);
    load_check("lbu", 32'h21, SZ_BYTE, 1'b1, 32'h00000080);
    load_check("lw_after_sb", 32'h20, SZ_WORD, 1'b0, 32'h11228044);
    load_check("lh", 32'h20, SZ_HALF, 1'b0, 32'hFFFF8044);
    load_check("lhu_hi", 32'h22, SZ_HALF, 1'b1, 32'h00001122);
    store(32'h12, 32'h0000CAFE, SZ_HALF);
    load_check("lw_after_sh", 32'h10, SZ_WORD, 1'b0, 32'hCAFEBEEF);

    // branch resolve
    nop();
    bus.Branch_in = 1'b1;
    bus.Zero_in = 1'b1;
    bus.BranchTarget_in = 32'h400;
    tick();
    check("br_taken", {31'h0, bus.PCSrc_out}, 32'h1);
    check("br_target", bus.BranchTarget_out, 32'h400);
    nop();
    tick();
    check("br_one_cycle", {31'h0, bus.PCSrc_out}, 32'h0);
    bus.Branch_in = 1'b1;
    bus.Zero_in = 1'b0;
    bus.BranchTarget_in = 32'h500;
    tick();
    check("br_not_taken", {31'h0, bus.PCSrc_out}, 32'h0);
    check("br_target2", bus.BranchTarget_out, 32'h500);
    nop();
    tick();

    // stall held three cycles over a store
    store(32'h30, 32'h11111111, SZ_WORD);
    alu_op(32'h1234, 5'd9);
    tick();
    st(32'h30, 32'h22222222, SZ_WORD);
    tick();
    ld(32'h30, 5'd10, SZ_WORD, 1'b0);
    bus.Stall_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_wbdata", bus.WBData_out, 32'h1234);
      check("stall_rw", {31'h0, bus.RegWrite_out}, 32'h1);
      check("stall_exalu", bus.ExMemALU_out, 32'h30);
    end
    bus.Stall_in = 1'b0;
    tick();
    check("stall_sw_rw", {31'h0, bus.RegWrite_out}, 32'h0);
    nop();
    tick();
    check("stall_lw_data", bus.WBData_out, 32'h22222222);
    check("stall_lw_dest", {27'h0, bus.WBDest_out}, 32'hA);

    // flush drops an ALU op and a store
    alu_op(32'hAB, 5'd11);
    bus.Flush_in = 1'b1;
    tick();
    bus.Flush_in = 1'b0;
    nop();
    check("flush_exrw", {31'h0, bus.ExMemRegWrite_out}, 32'h0);
    tick();
    check("flush_rw", {31'h0, bus.RegWrite_out}, 32'h0);
    store(32'h40, 32'h33333333, SZ_WORD);
    st(32'h40, 32'h44444444, SZ_WORD);
    bus.Flush_in = 1'b1;
    tick();
    bus.Flush_in = 1'b0;
    nop();
    tick();
    check("flush_sw_rw", {31'h0, bus.RegWrite_out}, 32'h0);
    tick();
    load_check("flush_sw_nowrite", 32'h40, SZ_WORD, 1'b0, 32'h33333333);

    // reset mid-run with a store pending in EX/MEM
    store(32'h50, 32'h55555555, SZ_WORD);
    alu_op(32'h99, 5'd4);
    tick();
    st(32'h50, 32'h66666666, SZ_WORD);
    tick();
    check("pre_rst_wb", bus.WBData_out, 32'h99);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("midrst");
    tick();
    rst_n = 1'b1;
    alu_op(32'h77, 5'd3);
    tick();
    check("restart_1edge_rw", {31'h0, bus.RegWrite_out}, 32'h0);
    nop();
    tick();
    check("restart_2edge_data", bus.WBData_out, 32'h77);
    check("restart_2edge_rw", {31'h0, bus.RegWrite_out}, 32'h1);
    load_check("rst_no_write", 32'h50, SZ_WORD, 1'b0, 32'h55555555);

    // misaligned word load
    ld(32'h13, 5'd7, SZ_WORD, 1'b0);
    tick();
    nop();
    tick();
`ifdef MEM_ALIGN_TRAP_EN
    check("mis_rw", {31'h0, bus.RegWrite_out}, 32'h0);
    check("mis_aerr", {31'h0, bus.AlignErr_out}, 32'h1);
    alu_op(32'h5, 5'd2);
    tick();
    tick();
    check("mis_aerr_sticky", {31'h0, bus.AlignErr_out}, 32'h1);
    check("mis_next_rw", {31'h0, bus.RegWrite_out}, 32'h1);
`else
    check("mis_data", bus.WBData_out, 32'hCAFEBEEF);
    check("mis_rw", {31'h0, bus.RegWrite_out}, 32'h1);
    check("mis_aerr", {31'h0, bus.AlignErr_out}, 32'h0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
